// File: rtl/fft64_frame_sched.sv
// rtl/fft64_frame_sched.sv - round-robin whole-frame scheduler and result tagger for the 64-point FFT core
// Define FFT_SCHED_OVERLAP_EN to load the next frame while the previous result is still streaming out.
module fft64_frame_sched #(
  parameter int NUM_CH = 4,
  parameter int CH_W   = 3
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NUM_CH-1:0]    s_valid,
  output logic [NUM_CH-1:0]    s_ready,
  input  logic [NUM_CH*24-1:0] s_real,
  input  logic [NUM_CH*24-1:0] s_imag,
  output logic                 core_din_valid,
  output logic [23:0]          core_din_real,
  output logic [23:0]          core_din_imag,
  input  logic                 core_dout_valid,
  input  logic [23:0]          core_dout_real,
  input  logic [23:0]          core_dout_imag,
  output logic                 m_valid,
  output logic [23:0]          m_real,
  output logic [23:0]          m_imag,
  output logic [CH_W-1:0]      m_ch,
  output logic                 m_last,
  output logic                 busy,
  output logic                 err
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [CH_W-1:0] grant, last_grant, pick;
  logic            pick_found;
  logic [5:0]      in_cnt, out_cnt;
  logic [CH_W-1:0] tag_mem [2];
  logic            wr_ptr, rd_ptr;
  logic [1:0]      occ;
  logic            sel_valid, push, pop, fifo_empty;

  // Search starts one past the previous owner so every requester gets a turn.
  always_comb begin
    pick       = '0;
    pick_found = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (!pick_found && s_valid[c] && (c == (int'(last_grant) + k) % NUM_CH)) begin
          pick_found = 1'b1;
          pick       = CH_W'(c);
        end
      end
    end
  end

  always_comb begin
    s_ready       = '0;
    sel_valid     = 1'b0;
    core_din_real = '0;
    core_din_imag = '0;
    if (state == LOAD) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (grant == CH_W'(c)) begin
          s_ready[c]    = 1'b1;
          sel_valid     = s_valid[c];
          core_din_real = s_real[24*c +: 24];
          core_din_imag = s_imag[24*c +: 24];
        end
      end
    end
  end

  assign core_din_valid = sel_valid;
  assign fifo_empty     = (occ == 2'd0);
  assign push           = (state == IDLE) && pick_found;
  assign pop            = core_dout_valid && (out_cnt == 6'd63) && !fifo_empty;
  assign busy           = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_found) state_nxt = LOAD;
      LOAD:  if (sel_valid && (in_cnt == 6'd63)) state_nxt = DRAIN;
      DRAIN: begin
`ifdef FFT_SCHED_OVERLAP_EN
        // The next start pulse is far enough behind the first result beat to be safe.
        if (core_dout_valid) state_nxt = IDLE;
`else
        if (pop) state_nxt = IDLE;
`endif
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      in_cnt     <= '0;
      out_cnt    <= '0;
      tag_mem[0] <= '0;
      tag_mem[1] <= '0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      occ        <= '0;
      m_valid    <= 1'b0;
      m_real     <= '0;
      m_imag     <= '0;
      m_ch       <= '0;
      m_last     <= 1'b0;
      err        <= 1'b0;
    end else begin
      if (push) begin
        grant           <= pick;
        tag_mem[wr_ptr] <= pick;
        wr_ptr          <= ~wr_ptr;
      end
      if (sel_valid) begin
        in_cnt <= in_cnt + 6'd1;
        if (in_cnt == 6'd63) last_grant <= grant;
      end
      if (core_dout_valid) out_cnt <= out_cnt + 6'd1;
      if (pop) rd_ptr <= ~rd_ptr;
      if (push && !pop)      occ <= occ + 2'd1;
      else if (pop && !push) occ <= occ - 2'd1;
      m_valid <= core_dout_valid;
      m_real  <= core_dout_real;
      m_imag  <= core_dout_imag;
      m_ch    <= (core_dout_valid && !fifo_empty) ? tag_mem[rd_ptr] : '0;
      m_last  <= core_dout_valid && (out_cnt == 6'd63);
      if (core_dout_valid && fifo_empty) err <= 1'b1;
    end
  end

endmodule

// File: doc/fft64_frame_sched.md
# fft64_frame_sched

Frame-level scheduler placed in front of the 64-point streaming FFT core. It shares the single core between NUM_CH sample sources using round-robin, whole-frame grants. It gates admission so that a new frame's start pulse can never disturb the butterfly registers while the previous result is still streaming out. Each output beat is tagged with the channel that produced the frame.

## Interface
- NUM_CH, 4: number of requesting channels (2..8).
- CH_W, 3: width of channel tag; must satisfy 2^CH_W ≥ NUM_CH.
- clk  in  1  system clock, all logic rising-edge.
- rstn  in  1  asynchronous, active-low reset.
- s_valid  in  NUM_CH  per-channel sample valid.
- s_ready  out  NUM_CH  per-channel sample accept; at most one bit high.
- s_real, s_imag  in  NUM_CH*24  per-channel signed samples; channel c occupies bits [24c+23:24c].
- core_din_valid  out  1  sample strobe to the core.
- core_din_real, core_din_imag  out  24  sample to the core.
- core_dout_valid  in  1  result strobe from the core.
- core_dout_real, core_dout_imag  in  24  result from the core.
- m_valid  out  1  tagged result valid; no backpressure.
- m_real, m_imag  out  24  result data.
- m_ch  out  CH_W  channel that owns the current result frame.
- m_last  out  1  high on the 64th beat of a result frame.
- busy  out  1  high whenever state ≠ IDLE or any frame is in flight.
- err  out  1  sticky: a core_dout_valid beat arrived with no frame pending.

## Operation
- The FSM has three states: IDLE, LOAD, DRAIN.
- IDLE:
  - If any s_valid bit is high, pick a grant g by round-robin, searching from last_grant+1 upward with wrap.
  - Register g, push g into the tag FIFO, and go to LOAD.
  - s_ready stays 0 in IDLE.
- LOAD:
  - s_ready[g] = 1.
  - core_din_valid = s_valid[g], and core_din_* = channel g's data, all combinational.
  - A beat is accepted when s_valid[g] is high; gaps are allowed.
  - The 6-bit in_cnt increments per accepted beat. The beat accepted with in_cnt=63 sets in_cnt to 0, updates last_grant to g, and moves the FSM to DRAIN.
  - A channel is never switched mid-frame.
- DRAIN: waits for the admission condition (see Configuration), then returns to IDLE.
- Output path:
  - m_valid, m_real and m_imag are core_dout_* registered by one cycle.
  - The 6-bit out_cnt counts core_dout_valid beats.
  - m_ch = tag FIFO head. m_last is asserted when out_cnt=63, and that beat pops the FIFO.
- Tag FIFO: depth 2, 2-bit occupancy. A push and a pop in the same cycle keeps occupancy unchanged.
- core_dout_valid with an empty FIFO sets err and outputs m_ch=0. err is cleared only by reset.
- Reset mid-frame:
  - All state clears: FSM to IDLE; in_cnt, out_cnt and FIFO emptied; last_grant = NUM_CH-1, so channel 0 wins first.
  - The core shares rstn, so a partial frame is discarded on both sides.

## Timing
- Reset values: s_ready=0, core_din_valid=0, core_din_*=0, m_valid=0, m_real=0, m_imag=0, m_ch=0, m_last=0, busy=0, err=0.
- Grant latency: s_valid is seen in IDLE at edge N; s_ready[g] goes high after edge N. The first sample can be accepted at edge N+1.
- Minimum load time is 64 cycles at full rate.
- Core latency is fixed: the first core_dout_valid comes 20 cycles after the edge that accepts sample 63. Results then arrive as 64 consecutive beats.
- m_* lags core_dout_* by exactly 1 cycle.
- Back-to-back frames without overlap: 1 (grant) + 64 + 20 + 64 cycles = 149-cycle period at full input rate.

## Configuration
- FFT_SCHED_OVERLAP_EN defined:
  - DRAIN exits to IDLE on the cycle the frame's first core_dout_valid is observed.
  - The next frame loads while the previous result streams out.
  - Safe because the next start pulse occurs at least 64 cycles later, and stage-5 re-latching occurs at least 16 cycles after that.
  - Tag FIFO occupancy may reach 2.
  - Period is 85 cycles.
- Not defined:
  - DRAIN exits only after the pop on that frame's 64th result beat.
  - FIFO occupancy never exceeds 1.

## Test plan
- Reset, then channel 2 alone sends 64 samples at full rate -> s_ready=4'b0100 one cycle after s_valid. m_valid is first high 21 cycles after the last accept, lasts 64 beats, m_ch=2, m_last on beat 64, busy drops afterwards.
- All four channels hold s_valid continuously -> grant order 0,1,2,3,0. s_ready is never multi-hot. Each frame's m_ch matches its grant.
- Channel 1 inserts 10 idle cycles mid-frame -> in_cnt holds, core_din_valid=0 during the gap, no channel switch, 64 samples are still delivered.
- Overlap enabled with channels 0 and 3 continuously valid -> channel 3 s_ready rises within 1 cycle of channel 0's first core_dout_valid. Results are correct and FIFO occupancy reaches 2. With the macro undefined, the next grant is 1 cycle after m_last.
- Inject core_dout_valid with an empty FIFO -> err=1 and stays set. Assert rstn low at in_cnt=30 -> all outputs return to reset values, and the next frame is granted to channel 0 with in_cnt starting at 0.
